// File: rtl/menu_niveles_param_pkg.sv
// Screen codes shared by the menu controller and the video block, plus a
// width helper for deriving counter widths from their maximum values.
package menu_pkg;

   typedef enum logic [2:0] {
      INICIO    = 3'b000,
      SELECCION = 3'b001,
      CARGA     = 3'b010,
      JUEGO     = 3'b111,
      GANAR     = 3'b101,
      PERDER    = 3'b110,
      FINALIZAR = 3'b100
   } estado_t;

   // Bits needed to represent values 0..v-1, never less than 1.
   function automatic int clog2(input longint unsigned v);
      int r;
      longint unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/menu_niveles_param_if.sv
// Front-panel buttons and game-core flags in; screen code, level, load
// strobe and lives out.
interface menu_niveles_param_if #(
   parameter int LVL_W   = 2,
   parameter int LIVES_W = 2
);
   logic               MN_START;
   logic               MN_UP;
   logic               MN_DOWN;
   logic               MN_GANO;
   logic               MN_PERDIO;
   logic [2:0]         MN_ESTADO_OUT;
   logic [LVL_W-1:0]   MN_NVL_OUT;
   logic               MN_CN_OUT;
   logic [LIVES_W-1:0] MN_VIDAS_OUT;

   modport master (
      output MN_START, MN_UP, MN_DOWN, MN_GANO, MN_PERDIO,
      input  MN_ESTADO_OUT, MN_NVL_OUT, MN_CN_OUT, MN_VIDAS_OUT
   );

   modport slave (
      input  MN_START, MN_UP, MN_DOWN, MN_GANO, MN_PERDIO,
      output MN_ESTADO_OUT, MN_NVL_OUT, MN_CN_OUT, MN_VIDAS_OUT
   );
endinterface

// File: rtl/menu_niveles_param_flanco_subida.sv
// Rising-edge detector for one debounced button. History resets to 1 so a
// button held through reset never produces a pulse.
module flanco_subida (
   input  logic clk,
   input  logic rst_n,
   input  logic nivel,
   output logic pulso
);
   logic previo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) previo <= 1'b1;
      else        previo <= nivel;
   end

   assign pulso = nivel & ~previo;
endmodule

// File: rtl/menu_niveles_param.sv
// Menu / game-flow controller: level select with wrap, lives with retry,
// campaign advance and timed auto-exit from the win/lose screens.
module menu_niveles_param
   import menu_pkg::*;
#(
   parameter int NUM_LEVELS = 4,
   parameter int LVL_W      = clog2(NUM_LEVELS),
   parameter int LIVES      = 3,
   parameter int LIVES_W    = clog2(LIVES + 1),
   parameter int TIMEOUT    = 150000000,
   parameter int TIMER_W    = clog2(TIMEOUT + 1)
) (
   input  logic             MN_CLOCK_50,
   input  logic             MN_RESET_N,
   menu_niveles_param_if.slave bus
);
   localparam logic [LVL_W-1:0]   LVL_LAST  = LVL_W'(NUM_LEVELS - 1);
   localparam logic [LIVES_W-1:0] LIVES_INI = LIVES_W'(LIVES);
   localparam logic [TIMER_W-1:0] T_LAST    = (TIMEOUT == 0) ? '0 : TIMER_W'(TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] T_MAX     = '1;

   estado_t             state;
   logic [LVL_W-1:0]    level;
   logic [LIVES_W-1:0]  lives;
   logic [TIMER_W-1:0]  timer;
   logic                start_p, up_p, down_p;
   logic                timeout_hit;
   logic [LVL_W-1:0]    level_inc, level_dec;

   flanco_subida u_start (.clk(MN_CLOCK_50), .rst_n(MN_RESET_N), .nivel(bus.MN_START), .pulso(start_p));
   flanco_subida u_up    (.clk(MN_CLOCK_50), .rst_n(MN_RESET_N), .nivel(bus.MN_UP),    .pulso(up_p));
   flanco_subida u_down  (.clk(MN_CLOCK_50), .rst_n(MN_RESET_N), .nivel(bus.MN_DOWN),  .pulso(down_p));

   assign level_inc   = (level == LVL_LAST) ? '0 : level + 1'b1;
   assign level_dec   = (level == '0) ? LVL_LAST : level - 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (timer == T_LAST);

   always_ff @(posedge MN_CLOCK_50 or negedge MN_RESET_N) begin
      if (!MN_RESET_N) begin
         state <= INICIO;
         level <= '0;
         lives <= LIVES_INI;
         timer <= '0;
      end else begin
         case (state)
            INICIO: begin
               if (start_p) begin
                  state <= SELECCION;
                  level <= '0;
               end
            end
            SELECCION: begin
               if (start_p) begin
                  lives <= LIVES_INI;
                  state <= CARGA;
               end else if (up_p ^ down_p) begin
                  level <= down_p ? level_inc : level_dec;
               end
            end
            CARGA: state <= JUEGO;
            JUEGO: begin
               // A win outranks a simultaneous life loss.
               if (bus.MN_GANO) begin
                  if (level == LVL_LAST) begin
                     state <= GANAR;
                     timer <= '0;
                  end else begin
                     level <= level_inc;
                     state <= CARGA;
                  end
               end else if (bus.MN_PERDIO) begin
                  if (lives == LIVES_W'(1)) begin
                     lives <= '0;
                     state <= PERDER;
                     timer <= '0;
                  end else begin
                     lives <= lives - 1'b1;
                     state <= CARGA;
                  end
               end
            end
            GANAR, PERDER: begin
               if (start_p || timeout_hit) state <= FINALIZAR;
               if (timer != T_MAX) timer <= timer + 1'b1;
            end
            FINALIZAR: begin
               state <= INICIO;
               level <= '0;
               lives <= LIVES_INI;
               timer <= '0;
            end
            default: state <= INICIO;
         endcase
      end
   end

   assign bus.MN_ESTADO_OUT = state;
   assign bus.MN_NVL_OUT    = level;
   assign bus.MN_CN_OUT     = (state == CARGA) || (state == FINALIZAR);
   assign bus.MN_VIDAS_OUT  = lives;
endmodule
